// File: rtl/johnson_decoder_if.sv
// rtl/johnson_decoder_if.sv - sample/result bundle for the Johnson-code decoder
interface johnson_decoder_if;
  logic       in_valid;
  logic [3:0] code;
  logic       err_clr;
  logic       out_valid;
  logic [2:0] value;
  logic       code_err;
  logic       seq_err;
  logic       locked;
  logic [7:0] err_count;

  modport master (
    output in_valid, code, err_clr,
    input  out_valid, value, code_err, seq_err, locked, err_count
  );

  modport slave (
    input  in_valid, code, err_clr,
    output out_valid, value, code_err, seq_err, locked, err_count
  );
endinterface

// File: rtl/johnson_decoder.sv
// rtl/johnson_decoder.sv - 4-bit Johnson code decoder with lock FSM and error counter
module johnson_decoder #(
  parameter bit ALLOW_HOLD = 1'b1
) (
  input logic              clk,
  input logic              reset,
  johnson_decoder_if.slave bus
);

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_ACQUIRE  = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;

  logic [1:0] state_q, state_d;
  logic [2:0] prev_q, prev_d;
  logic       out_valid_q, out_valid_d;
  logic       code_err_q, code_err_d;
  logic       seq_err_q, seq_err_d;
  logic [7:0] err_count_q;

  logic       legal;
  logic [2:0] idx;
  logic       is_succ;
  logic       is_hold;

  always_comb begin
    legal = 1'b1;
    idx   = 3'd0;
    case (bus.code)
      4'b0001: idx = 3'd0;
      4'b0011: idx = 3'd1;
      4'b0111: idx = 3'd2;
      4'b1111: idx = 3'd3;
      4'b1110: idx = 3'd4;
      4'b1100: idx = 3'd5;
      4'b1000: idx = 3'd6;
      4'b0000: idx = 3'd7;
      default: legal = 1'b0;
    endcase
  end

  // 3-bit addition wraps 7 -> 0, which makes 0000 -> 0001 a normal successor
  assign is_succ = (idx == prev_q + 3'd1);
  assign is_hold = (idx == prev_q);

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    out_valid_d = 1'b0;
    code_err_d  = 1'b0;
    seq_err_d   = 1'b0;
    if (bus.in_valid) begin
      if (!legal) begin
        code_err_d = 1'b1;
        state_d    = ST_UNLOCKED;
      end else begin
        out_valid_d = 1'b1;
        prev_d      = idx;
        case (state_q)
          ST_UNLOCKED: state_d = ST_ACQUIRE;
          ST_ACQUIRE:  state_d = is_succ ? ST_LOCKED : ST_ACQUIRE;
          ST_LOCKED: begin
            if (is_succ || (is_hold && ALLOW_HOLD)) begin
              state_d = ST_LOCKED;
            end else begin
              seq_err_d = 1'b1;
              state_d   = ST_ACQUIRE;
            end
          end
          default: state_d = ST_UNLOCKED;
        endcase
      end
    end
  end

  // prev doubles as the reported value: both track the last legal index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_UNLOCKED;
      prev_q      <= 3'd0;
      out_valid_q <= 1'b0;
      code_err_q  <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      out_valid_q <= out_valid_d;
      code_err_q  <= code_err_d;
      seq_err_q   <= seq_err_d;
    end
  end

  // Counter moves on the same edge as the error pulse so both are seen together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count_q <= 8'd0;
    end else if (bus.err_clr) begin
      err_count_q <= 8'd0;
    end else if ((code_err_d || seq_err_d) && (err_count_q != 8'hff)) begin
      err_count_q <= err_count_q + 8'd1;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.value     = prev_q;
  assign bus.code_err  = code_err_q;
  assign bus.seq_err   = seq_err_q;
  assign bus.locked    = (state_q == ST_LOCKED);
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// tb/tb_johnson_decoder.sv - directed self-checking bench for johnson_decoder
module tb_johnson_decoder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  johnson_decoder_if bus1 ();
  johnson_decoder_if bus0 ();

  assign bus0.in_valid = bus1.in_valid;
  assign bus0.code     = bus1.code;
  assign bus0.err_clr  = bus1.err_clr;

  johnson_decoder #(.ALLOW_HOLD(1'b1)) dut_hold   (.clk(clk), .reset(reset), .bus(bus1));
  johnson_decoder #(.ALLOW_HOLD(1'b0)) dut_nohold (.clk(clk), .reset(reset), .bus(bus0));

  always #5 clk = ~clk;

  logic [3:0] seq [0:8];
  initial begin
    seq[0] = 4'b0001; seq[1] = 4'b0011; seq[2] = 4'b0111;
    seq[3] = 4'b1111; seq[4] = 4'b1110; seq[5] = 4'b1100;
    seq[6] = 4'b1000; seq[7] = 4'b0000; seq[8] = 4'b0001;
  end

  task automatic drive(input logic v, input logic [3:0] c, input logic clr);
    bus1.in_valid = v;
    bus1.code     = c;
    bus1.err_clr  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus1.in_valid = 1'b0;
    bus1.code     = 4'b0000;
    bus1.err_clr  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus1.in_valid = 1'b0;
    bus1.code     = 4'b0000;
    bus1.err_clr  = 1'b0;
    #2;
    checks++;
    if ({bus1.out_valid, bus1.value, bus1.code_err, bus1.seq_err, bus1.locked, bus1.err_count} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs got ov=%b val=%0d ce=%b se=%b lk=%b cnt=%0d want all 0",
               bus1.out_valid, bus1.value, bus1.code_err, bus1.seq_err, bus1.locked, bus1.err_count);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_lock_wrap();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      logic [2:0] ev;
      logic       el;
      ev = 3'(i % 8);
      el = (i >= 1);
      drive(1'b1, seq[i], 1'b0);
      checks++;
      if (bus1.out_valid !== 1'b1 || bus1.value !== ev || bus1.locked !== el ||
          bus1.code_err !== 1'b0 || bus1.seq_err !== 1'b0 || bus1.err_count !== 8'd0) begin
        errors++;
        $display("FAIL lock_wrap[%0d] got ov=%b val=%0d lk=%b ce=%b se=%b cnt=%0d want ov=1 val=%0d lk=%b no errors",
                 i, bus1.out_valid, bus1.value, bus1.locked, bus1.code_err, bus1.seq_err, bus1.err_count, ev, el);
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    drive(1'b1, 4'b0001, 1'b0);
    drive(1'b1, 4'b0011, 1'b0);
    drive(1'b1, 4'b0111, 1'b0);
    drive(1'b1, 4'b0101, 1'b0);
    checks++;
    if (bus1.code_err !== 1'b1 || bus1.seq_err !== 1'b0 || bus1.out_valid !== 1'b0 ||
        bus1.value !== 3'd2 || bus1.locked !== 1'b0 || bus1.err_count !== 8'd1) begin
      errors++;
      $display("FAIL illegal_code got ce=%b se=%b ov=%b val=%0d lk=%b cnt=%0d want ce=1 se=0 ov=0 val=2 lk=0 cnt=1",
               bus1.code_err, bus1.seq_err, bus1.out_valid, bus1.value, bus1.locked, bus1.err_count);
    end
    drive(1'b1, 4'b1111, 1'b0);
    checks++;
    if (bus1.out_valid !== 1'b1 || bus1.value !== 3'd3 || bus1.locked !== 1'b0 ||
        bus1.code_err !== 1'b0 || bus1.seq_err !== 1'b0) begin
      errors++;
      $display("FAIL illegal_recover got ov=%b val=%0d lk=%b ce=%b se=%b want ov=1 val=3 lk=0 ce=0 se=0",
               bus1.out_valid, bus1.value, bus1.locked, bus1.code_err, bus1.seq_err);
    end
  endtask

  task automatic test_skip();
    do_reset();
    drive(1'b1, 4'b0001, 1'b0);
    drive(1'b1, 4'b0011, 1'b0);
    drive(1'b1, 4'b1111, 1'b0);
    checks++;
    if (bus1.seq_err !== 1'b1 || bus1.code_err !== 1'b0 || bus1.out_valid !== 1'b1 ||
        bus1.value !== 3'd3 || bus1.locked !== 1'b0 || bus1.err_count !== 8'd1) begin
      errors++;
      $display("FAIL seq_skip got se=%b ce=%b ov=%b val=%0d lk=%b cnt=%0d want se=1 ce=0 ov=1 val=3 lk=0 cnt=1",
               bus1.seq_err, bus1.code_err, bus1.out_valid, bus1.value, bus1.locked, bus1.err_count);
    end
    drive(1'b1, 4'b1110, 1'b0);
    checks++;
    if (bus1.locked !== 1'b1 || bus1.value !== 3'd4 || bus1.seq_err !== 1'b0 || bus1.err_count !== 8'd1) begin
      errors++;
      $display("FAIL seq_relock got lk=%b val=%0d se=%b cnt=%0d want lk=1 val=4 se=0 cnt=1",
               bus1.locked, bus1.value, bus1.seq_err, bus1.err_count);
    end
  endtask

  task automatic test_hold();
    do_reset();
    for (int i = 0; i < 6; i++) drive(1'b1, seq[i], 1'b0);
    for (int r = 0; r < 2; r++) begin
      logic es0;
      es0 = (r == 0);
      drive(1'b1, 4'b1100, 1'b0);
      checks++;
      if (bus1.out_valid !== 1'b1 || bus1.value !== 3'd5 || bus1.locked !== 1'b1 ||
          bus1.seq_err !== 1'b0 || bus1.code_err !== 1'b0 || bus1.err_count !== 8'd0) begin
        errors++;
        $display("FAIL hold_allowed[%0d] got ov=%b val=%0d lk=%b se=%b ce=%b cnt=%0d want ov=1 val=5 lk=1 no errors",
                 r, bus1.out_valid, bus1.value, bus1.locked, bus1.seq_err, bus1.code_err, bus1.err_count);
      end
      checks++;
      if (bus0.out_valid !== 1'b1 || bus0.value !== 3'd5 || bus0.locked !== 1'b0 ||
          bus0.seq_err !== es0 || bus0.code_err !== 1'b0 || bus0.err_count !== 8'd1) begin
        errors++;
        $display("FAIL hold_denied[%0d] got ov=%b val=%0d lk=%b se=%b ce=%b cnt=%0d want ov=1 val=5 lk=0 se=%b ce=0 cnt=1",
                 r, bus0.out_valid, bus0.value, bus0.locked, bus0.seq_err, bus0.code_err, bus0.err_count, es0);
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 4'b0010, 1'b0);
      if (i == 253 || i == 254 || i == 299) begin
        logic [7:0] ec;
        ec = (i == 253) ? 8'd254 : 8'd255;
        checks++;
        if (bus1.err_count !== ec || bus1.code_err !== 1'b1) begin
          errors++;
          $display("FAIL saturate[%0d] got cnt=%0d ce=%b want cnt=%0d ce=1", i, bus1.err_count, bus1.code_err, ec);
        end
      end
    end
    drive(1'b1, 4'b1010, 1'b1);
    checks++;
    if (bus1.err_count !== 8'd0 || bus1.code_err !== 1'b1) begin
      errors++;
      $display("FAIL clear_priority got cnt=%0d ce=%b want cnt=0 ce=1", bus1.err_count, bus1.code_err);
    end
    drive(1'b1, 4'b1101, 1'b0);
    checks++;
    if (bus1.err_count !== 8'd1) begin
      errors++;
      $display("FAIL count_after_clear got cnt=%0d want 1", bus1.err_count);
    end
  endtask

  task automatic test_gaps_and_reset();
    do_reset();
    drive(1'b1, 4'b0001, 1'b0);
    drive(1'b0, 4'b0101, 1'b0);
    checks++;
    if (bus1.out_valid !== 1'b0 || bus1.value !== 3'd0 || bus1.locked !== 1'b0 || bus1.code_err !== 1'b0) begin
      errors++;
      $display("FAIL gap_acquire got ov=%b val=%0d lk=%b ce=%b want ov=0 val=0 lk=0 ce=0",
               bus1.out_valid, bus1.value, bus1.locked, bus1.code_err);
    end
    drive(1'b1, 4'b0011, 1'b0);
    drive(1'b0, 4'b1111, 1'b0);
    checks++;
    if (bus1.out_valid !== 1'b0 || bus1.value !== 3'd1 || bus1.locked !== 1'b1 || bus1.seq_err !== 1'b0) begin
      errors++;
      $display("FAIL gap_locked got ov=%b val=%0d lk=%b se=%b want ov=0 val=1 lk=1 se=0",
               bus1.out_valid, bus1.value, bus1.locked, bus1.seq_err);
    end
    drive(1'b1, 4'b0111, 1'b0);
    checks++;
    if (bus1.out_valid !== 1'b1 || bus1.value !== 3'd2 || bus1.locked !== 1'b1 || bus1.err_count !== 8'd0) begin
      errors++;
      $display("FAIL gap_resume got ov=%b val=%0d lk=%b cnt=%0d want ov=1 val=2 lk=1 cnt=0",
               bus1.out_valid, bus1.value, bus1.locked, bus1.err_count);
    end
    drive(1'b1, 4'b0110, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({bus1.out_valid, bus1.value, bus1.code_err, bus1.seq_err, bus1.locked, bus1.err_count} !== 15'd0) begin
      errors++;
      $display("FAIL async_reset got ov=%b val=%0d ce=%b se=%b lk=%b cnt=%0d want all 0",
               bus1.out_valid, bus1.value, bus1.code_err, bus1.seq_err, bus1.locked, bus1.err_count);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 4'b1111, 1'b0);
    checks++;
    if (bus1.out_valid !== 1'b1 || bus1.value !== 3'd3 || bus1.locked !== 1'b0 || bus1.seq_err !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_acquire got ov=%b val=%0d lk=%b se=%b want ov=1 val=3 lk=0 se=0",
               bus1.out_valid, bus1.value, bus1.locked, bus1.seq_err);
    end
  endtask

  initial begin
    test_reset();
    test_lock_wrap();
    test_illegal();
    test_skip();
    test_hold();
    test_saturate();
    test_gaps_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/johnson_decoder.md
JOHNSON_DECODER -- requirements
Module: johnson_decoder

Interface
REQ-001 Parameter ALLOW_HOLD, default 1: when 1, a legal code equal to the previous legal code is accepted as a hold and raises no error.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  qualifies code for the current cycle.
REQ-005 code  input  4  Johnson-coded sample from a 4-bit Johnson counter.
REQ-006 err_clr  input  1  synchronous clear of err_count.
REQ-007 out_valid  output  1  one-cycle pulse: value carries a newly decoded legal code.
REQ-008 value  output  3  binary index of the last legal code.
REQ-009 code_err  output  1  one-cycle pulse: the sampled code was illegal.
REQ-010 seq_err  output  1  one-cycle pulse: the code was legal but out of sequence while LOCKED.
REQ-011 locked  output  1  high while the FSM is in LOCKED.
REQ-012 err_count  output  8  saturating error count.

Function
REQ-013 Legal code map, code->index: 0001->0, 0011->1, 0111->2, 1111->3, 1110->4, 1100->5, 1000->6, 0000->7.
REQ-014 The remaining 8 codes (0010, 0100, 0101, 0110, 1001, 1010, 1011, 1101) are illegal.
REQ-015 Successor of index i is (i+1) mod 8; 0000 (7) -> 0001 (0) is a legal wrap, not an error.
REQ-016 All outputs are registered: a sample taken at edge N is reflected at edge N+1, so latency is 1 cycle.
REQ-017 When in_valid=0: no state change; out_valid, code_err and seq_err are 0; value holds.
REQ-018 Legal sample: out_valid=1, value=index, and the prev register is loaded with the index.
REQ-019 Illegal sample: code_err=1, out_valid=0, value and prev hold.
REQ-020 FSM states: UNLOCKED, ACQUIRE, LOCKED.
REQ-021 UNLOCKED: legal -> ACQUIRE; illegal -> stays UNLOCKED.
REQ-022 ACQUIRE: successor -> LOCKED; legal non-successor -> stays ACQUIRE; illegal -> UNLOCKED.
REQ-023 LOCKED: successor -> stays LOCKED.
REQ-024 LOCKED: hold with ALLOW_HOLD=1 -> stays LOCKED with no error; out_valid=1 with the same value.
REQ-025 LOCKED: legal non-successor, or hold with ALLOW_HOLD=0 -> seq_err=1, go to ACQUIRE.
REQ-026 LOCKED: illegal -> code_err=1, go to UNLOCKED.
REQ-027 seq_err is never asserted in UNLOCKED or ACQUIRE.
REQ-028 code_err and seq_err are mutually exclusive in any cycle.
REQ-029 err_count increments by 1 on each cycle in which code_err or seq_err is asserted.
REQ-030 err_count saturates at 255 and does not wrap.
REQ-031 err_clr sets err_count to 0 at the next edge and takes precedence over a simultaneous increment.
REQ-032 err_clr does not affect the FSM, value, prev or the pulse outputs.

Reset
REQ-033 Asserting reset immediately forces: FSM to UNLOCKED, prev=0, value=0, out_valid=0, code_err=0, seq_err=0, locked=0, err_count=0.
REQ-034 Reset mid-sequence discards lock: the first legal code after release enters ACQUIRE and never raises seq_err.
REQ-035 The first edge after reset deassertion samples inputs normally.

Verification
REQ-036 Lock and wrap: after reset, drive the 0001, 0011, ..., 0000, 0001 sequence with in_valid=1 every cycle -> value 0..7,0; locked high from the 2nd output onward; no errors; err_count=0.
REQ-037 Illegal code: while LOCKED at 0111, drive 0101 -> code_err pulse, value stays 2, locked=0, err_count=1; the next 1111 gives value=3 and ACQUIRE, not LOCKED.
REQ-038 Sequence skip: while LOCKED at 0011, drive 1111 -> seq_err pulse, value=3, locked=0, err_count+1; then 1110 -> locked=1.
REQ-039 Hold: while LOCKED at 1100, drive 1100 twice -> ALLOW_HOLD=1: no error, out_valid=1, value=5; ALLOW_HOLD=0: seq_err on the first repeat.
REQ-040 Saturation and clear: inject 300 illegal codes -> err_count=255; err_clr together with an error -> err_count=0.
REQ-041 in_valid gaps and reset: legal sequence with in_valid=0 cycles interleaved -> still locked, no errors; assert reset between edges -> all outputs 0 immediately.
